video_stream_pattern_gen: RTL and testbench

Configurable AXI4-Stream video test-pattern source sitting directly upstream of the video_stream_not stage in the processing chain. It generates complete raster frames (solid colour, horizontal ramp, vertical ramp, checkerboard) with SOF on tuser and EOL on tlast, fully honouring downstream backpressure. It is used for in-system bring-up and as the standard stimulus source for downstream stages.

---
 rtl/video_stream_pattern_gen.sv | 189 ++++++++++++++++++
 tb/tb_video_stream_pattern_gen.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_pattern_gen.sv
// AXI4-Stream video test-pattern source: raster frames of solid, ramp or checkerboard pixels
// with start-of-frame on tuser and end-of-line on tlast, honouring downstream backpressure.
module video_stream_pattern_gen #(
  parameter int DATA_WIDTH = 24,
  parameter int DIM_WIDTH  = 16,
  parameter int FRAME_GAP  = 0,
  parameter int CHECK_LOG2 = 3
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  input  logic [DIM_WIDTH-1:0]  frame_width,
  input  logic [DIM_WIDTH-1:0]  frame_height,
  input  logic [DATA_WIDTH-1:0] solid_color,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic [31:0]           frame_count,
  output logic                  busy
);

  localparam int NUM_CH = DATA_WIDTH / 8;
  localparam int GAP_W  = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [GAP_W-1:0]     GAP_ZERO = GAP_W'(0);
  localparam logic [GAP_W-1:0]     GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0]     GAP_LAST = (FRAME_GAP > 0) ? GAP_W'(FRAME_GAP - 1) : GAP_W'(0);
  localparam logic [DIM_WIDTH-1:0] DIM_ZERO = DIM_WIDTH'(0);
  localparam logic [DIM_WIDTH-1:0] DIM_ONE  = DIM_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  state_t                state_r;
  logic [DIM_WIDTH-1:0]  x_r;
  logic [DIM_WIDTH-1:0]  y_r;
  logic [1:0]            sel_r;
  logic [DIM_WIDTH-1:0]  width_r;
  logic [DIM_WIDTH-1:0]  height_r;
  logic [DATA_WIDTH-1:0] solid_r;
  logic [GAP_W-1:0]      gap_cnt_r;
  logic [DATA_WIDTH-1:0] tdata_r;
  logic                  tvalid_r;
  logic                  tuser_r;
  logic                  tlast_r;
  logic [31:0]           frame_count_r;
  logic                  busy_r;

  logic                  last_x_s;
  logic                  last_px_s;
  logic [DIM_WIDTH-1:0]  x_nxt_s;
  logic [DIM_WIDTH-1:0]  y_nxt_s;
  logic                  start_ok_s;
  logic                  decide_s;

  // Every channel carries the same byte except for the solid pattern.
  function automatic logic [DATA_WIDTH-1:0] pixel_value(
    input logic [1:0]            sel,
    input logic [7:0]            x_lo,
    input logic [7:0]            y_lo,
    input logic                  x_chk,
    input logic                  y_chk,
    input logic [DATA_WIDTH-1:0] solid
  );
    logic [7:0]            ch;
    logic [DATA_WIDTH-1:0] pix;
    pix = {DATA_WIDTH{1'b0}};
    case (sel)
      2'd1:    ch = x_lo;
      2'd2:    ch = y_lo;
      2'd3:    ch = (x_chk ^ y_chk) ? 8'hFF : 8'h00;
      default: ch = 8'h00;
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      pix[c*8 +: 8] = ch;
    end
    return (sel == 2'd0) ? solid : pix;
  endfunction

  // Raster position advance and the frame-boundary decision point.
  always_comb begin
    last_x_s  = (x_r == width_r - DIM_ONE);
    last_px_s = last_x_s && (y_r == height_r - DIM_ONE);
    if (last_x_s) begin
      x_nxt_s = DIM_ZERO;
      y_nxt_s = y_r + DIM_ONE;
    end else begin
      x_nxt_s = x_r + DIM_ONE;
      y_nxt_s = y_r;
    end
    start_ok_s = enable && (frame_width != DIM_ZERO) && (frame_height != DIM_ZERO);
    case (state_r)
      ST_IDLE:   decide_s = 1'b1;
      ST_ACTIVE: decide_s = m_axis_tready && last_px_s && (FRAME_GAP == 0);
      ST_GAP:    decide_s = (gap_cnt_r == GAP_LAST);
      default:   decide_s = 1'b1;
    endcase
  end

  // Frame sequencer with registered stream outputs; a start at a decision point overrides the per-state update.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_r       <= ST_IDLE;
      x_r           <= DIM_ZERO;
      y_r           <= DIM_ZERO;
      sel_r         <= 2'd0;
      width_r       <= DIM_ZERO;
      height_r      <= DIM_ZERO;
      solid_r       <= {DATA_WIDTH{1'b0}};
      gap_cnt_r     <= GAP_ZERO;
      tdata_r       <= {DATA_WIDTH{1'b0}};
      tvalid_r      <= 1'b0;
      tuser_r       <= 1'b0;
      tlast_r       <= 1'b0;
      frame_count_r <= 32'd0;
      busy_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_ACTIVE: begin
          if (m_axis_tready) begin
            if (last_px_s) begin
              frame_count_r <= frame_count_r + 32'd1;
              tvalid_r      <= 1'b0;
              tuser_r       <= 1'b0;
              tlast_r       <= 1'b0;
              state_r       <= ST_GAP;
              gap_cnt_r     <= GAP_ZERO;
            end else begin
              x_r     <= x_nxt_s;
              y_r     <= y_nxt_s;
              tdata_r <= pixel_value(sel_r, x_nxt_s[7:0], y_nxt_s[7:0],
                                     x_nxt_s[CHECK_LOG2], y_nxt_s[CHECK_LOG2], solid_r);
              tuser_r <= 1'b0;
              tlast_r <= (x_nxt_s == width_r - DIM_ONE);
            end
          end
        end
        ST_GAP: begin
          gap_cnt_r <= gap_cnt_r + GAP_ONE;
        end
        ST_IDLE: begin
          tvalid_r <= 1'b0;
          busy_r   <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          tvalid_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase

      if (decide_s) begin
        if (start_ok_s) begin
          state_r  <= ST_ACTIVE;
          sel_r    <= pattern_sel;
          width_r  <= frame_width;
          height_r <= frame_height;
          solid_r  <= solid_color;
          x_r      <= DIM_ZERO;
          y_r      <= DIM_ZERO;
          tdata_r  <= pixel_value(pattern_sel, 8'h00, 8'h00, 1'b0, 1'b0, solid_color);
          tvalid_r <= 1'b1;
          tuser_r  <= 1'b1;
          tlast_r  <= (frame_width == DIM_ONE);
          busy_r   <= 1'b1;
        end else begin
          state_r  <= ST_IDLE;
          tvalid_r <= 1'b0;
          tuser_r  <= 1'b0;
          tlast_r  <= 1'b0;
          busy_r   <= 1'b0;
        end
      end
    end
  end

  assign m_axis_tdata  = tdata_r;
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tuser  = tuser_r;
  assign m_axis_tlast  = tlast_r;
  assign frame_count   = frame_count_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_video_stream_pattern_gen.sv
// Scoreboard bench: directed frames push expected beats; a negedge monitor pops and compares
// on every transfer, checks held beats during stalls, and measures the inter-frame gap.
module tb_video_stream_pattern_gen;

  typedef struct packed {
    logic [23:0] data;
    logic        user;
    logic        last;
    logic        eof;
  } beat_t;

  logic        clk = 1'b0;
  logic        areset;
  logic        en0;
  logic        en_g;
  logic        tready;
  logic [1:0]  pattern_sel;
  logic [15:0] frame_width;
  logic [15:0] frame_height;
  logic [23:0] solid_color;
  logic [23:0] tdata0, tdata_g;
  logic        tvalid0, tuser0, tlast0, busy0;
  logic        tvalid_g, tuser_g, tlast_g, busy_g;
  logic [31:0] fc0, fc_g;

  beat_t q0[$];
  beat_t qg[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    rand_rdy = 1'b0;
  bit    stall0   = 1'b0;
  bit    stall_g  = 1'b0;
  bit    g_after_eof = 1'b0;
  int    g_low_run   = 0;

  logic [23:0] hr_tab [8] = '{24'h000000, 24'h010101, 24'h020202, 24'h030303,
                              24'h000000, 24'h010101, 24'h020202, 24'h030303};
  logic [23:0] vr_tab [4] = '{24'h000000, 24'h000000, 24'h010101, 24'h010101};

  video_stream_pattern_gen #(.DATA_WIDTH(24), .DIM_WIDTH(16), .FRAME_GAP(0), .CHECK_LOG2(3)) dut0 (
    .ACLK(clk), .ARESET(areset), .enable(en0), .pattern_sel(pattern_sel),
    .frame_width(frame_width), .frame_height(frame_height), .solid_color(solid_color),
    .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0), .m_axis_tready(tready),
    .m_axis_tuser(tuser0), .m_axis_tlast(tlast0), .frame_count(fc0), .busy(busy0)
  );

  video_stream_pattern_gen #(.DATA_WIDTH(24), .DIM_WIDTH(16), .FRAME_GAP(3), .CHECK_LOG2(3)) dut_g (
    .ACLK(clk), .ARESET(areset), .enable(en_g), .pattern_sel(pattern_sel),
    .frame_width(frame_width), .frame_height(frame_height), .solid_color(solid_color),
    .m_axis_tdata(tdata_g), .m_axis_tvalid(tvalid_g), .m_axis_tready(tready),
    .m_axis_tuser(tuser_g), .m_axis_tlast(tlast_g), .frame_count(fc_g), .busy(busy_g)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic push(input bit to_g, input logic [23:0] d, input logic u, input logic l, input logic e);
    beat_t b;
    b.data = d;
    b.user = u;
    b.last = l;
    b.eof  = e;
    if (to_g) qg.push_back(b);
    else      q0.push_back(b);
  endtask

  task automatic push_hramp8();
    for (int i = 0; i < 8; i++) push(1'b0, hr_tab[i], i == 0, (i == 3) || (i == 7), i == 7);
  endtask

  // Pop on transfer (pop=1) or peek during a stall (pop=0), comparing against the expected head.
  task automatic score(input bit gq, input bit pop, input logic [23:0] d, input logic u,
                       input logic l, output logic eof);
    beat_t e;
    string nm;
    nm  = gq ? "dut_g" : "dut0";
    eof = 1'b0;
    n_checks++;
    if ((gq ? qg.size() : q0.size()) == 0) begin
      n_fail++;
      $display("FAIL %s %s: got data=%06h user=%0b last=%0b, expected no beat",
               nm, pop ? "unexpected beat" : "unexpected stall", d, u, l);
    end else begin
      if (pop) e = gq ? qg.pop_front() : q0.pop_front();
      else     e = gq ? qg[0] : q0[0];
      eof = pop ? e.eof : 1'b0;
      if ({d, u, l} !== {e.data, e.user, e.last}) begin
        n_fail++;
        $display("FAIL %s %s: got data=%06h user=%0b last=%0b, expected data=%06h user=%0b last=%0b",
                 nm, pop ? "beat" : "stall hold", d, u, l, e.data, e.user, e.last);
      end
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((q0.size() + qg.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk({name, " drain"}, q0.size() + qg.size(), 32'd0);
    q0.delete();
    qg.delete();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic pulse_en0();
    @(posedge clk); #1 en0 = 1'b1;
    @(posedge clk); #1 en0 = 1'b0;
  endtask

  // tready: always 1, or a coin flip each cycle when random backpressure is on.
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  initial begin
    forever begin
      logic eof_s;
      @(negedge clk);
      if (areset) begin
        stall0      = 1'b0;
        stall_g     = 1'b0;
        g_after_eof = 1'b0;
        g_low_run   = 0;
      end else begin
        if (stall0) chk_bit("dut0 tvalid held in stall", tvalid0, 1'b1);
        if (tvalid0) begin
          score(1'b0, tready, tdata0, tuser0, tlast0, eof_s);
          stall0 = !tready;
        end else begin
          stall0 = 1'b0;
        end

        if (stall_g) chk_bit("dut_g tvalid held in stall", tvalid_g, 1'b1);
        if (tvalid_g) begin
          if (g_after_eof) begin
            chk("dut_g gap length", g_low_run, 32'd3);
            g_after_eof = 1'b0;
          end
          score(1'b1, tready, tdata_g, tuser_g, tlast_g, eof_s);
          stall_g = !tready;
          if (tready && eof_s) begin
            g_after_eof = 1'b1;
            g_low_run   = 0;
          end
        end else begin
          stall_g = 1'b0;
          if (g_after_eof) g_low_run++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    areset = 1'b1; en0 = 1'b0; en_g = 1'b0;
    pattern_sel = 2'd1; frame_width = 16'd4; frame_height = 16'd2; solid_color = 24'h123456;
    @(posedge clk); #1;
    chk_bit("reset tvalid", tvalid0, 1'b0);
    chk("reset tdata", 32'(tdata0), 32'd0);
    chk_bit("reset tuser", tuser0, 1'b0);
    chk_bit("reset tlast", tlast0, 1'b0);
    chk("reset frame_count", fc0, 32'd0);
    chk_bit("reset busy", busy0, 1'b0);
    chk_bit("reset busy gap dut", busy_g, 1'b0);
    areset = 1'b0;

    // 4x2 h-ramp, full throughput, single enable pulse
    push_hramp8();
    pulse_en0();
    chk_bit("sof latency tvalid", tvalid0, 1'b1);
    chk_bit("busy first active", busy0, 1'b1);
    wait_drain("hramp", 50);
    chk("hramp frame_count", fc0, 32'd1);
    chk_bit("hramp idle busy", busy0, 1'b0);
    chk_bit("hramp idle tvalid", tvalid0, 1'b0);

    // same frame under random backpressure
    rand_rdy = 1'b1;
    push_hramp8();
    pulse_en0();
    wait_drain("hramp backpressure", 300);
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("backpressure frame_count", fc0, 32'd2);

    // 16x16 checkerboard, 8-pixel squares
    pattern_sel = 2'd3; frame_width = 16'd16; frame_height = 16'd16;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        push(1'b0, ((((x / 8) + (y / 8)) % 2) == 1) ? 24'hFFFFFF : 24'h000000,
             (x == 0) && (y == 0), x == 15, (x == 15) && (y == 15));
    pulse_en0();
    wait_drain("checker", 400);
    chk("checker frame_count", fc0, 32'd3);

    // 2x2 v-ramp on the FRAME_GAP=3 instance, enable held for two frames
    pattern_sel = 2'd2; frame_width = 16'd2; frame_height = 16'd2;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 4; i++) push(1'b1, vr_tab[i], i == 0, (i == 1) || (i == 3), i == 3);
    @(posedge clk); #1 en_g = 1'b1;
    n = 0;
    while (fc_g != 32'd1 && n < 50) begin @(posedge clk); #1; n++; end
    chk("gap frame_count after frame 1", fc_g, 32'd1);
    chk_bit("busy during gap", busy_g, 1'b1);
    chk_bit("tvalid low during gap", tvalid_g, 1'b0);
    n = 0;
    while (tvalid_g != 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk_bit("second frame started", tvalid_g, 1'b1);
    en_g = 1'b0;
    wait_drain("vramp gap", 50);
    chk("gap frame_count after frame 2", fc_g, 32'd2);
    chk_bit("gap idle busy", busy_g, 1'b0);

    // config changes and enable drop during pixel 2 of a 4x2 h-ramp
    pattern_sel = 2'd1; frame_width = 16'd4; frame_height = 16'd2;
    push_hramp8();
    @(posedge clk); #1 en0 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    pattern_sel = 2'd2; frame_width = 16'd8; en0 = 1'b0;
    wait_drain("midframe", 50);
    chk("midframe frame_count", fc0, 32'd4);
    chk_bit("midframe idle busy", busy0, 1'b0);

    // zero width: nothing is produced
    frame_width = 16'd0; en0 = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk_bit("zero width tvalid", tvalid0, 1'b0);
    chk_bit("zero width busy", busy0, 1'b0);
    en0 = 1'b0;

    // asynchronous reset while beat 5 is presented
    pattern_sel = 2'd1; frame_width = 16'd4;
    for (int i = 0; i < 5; i++) push(1'b0, hr_tab[i], i == 0, i == 3, 1'b0);
    pulse_en0();
    repeat (5) @(posedge clk); #1;
    chk_bit("beat 5 valid before reset", tvalid0, 1'b1);
    chk("beat 5 data before reset", 32'(tdata0), 32'h010101);
    chk("beats consumed before reset", q0.size(), 32'd0);
    #1 areset = 1'b1;
    #1;
    chk_bit("async reset tvalid", tvalid0, 1'b0);
    chk_bit("async reset tuser", tuser0, 1'b0);
    chk_bit("async reset tlast", tlast0, 1'b0);
    chk("async reset frame_count", fc0, 32'd0);
    chk("async reset frame_count gap dut", fc_g, 32'd0);
    chk_bit("async reset busy", busy0, 1'b0);
    en0 = 1'b1;
    push_hramp8();
    @(posedge clk); #1 areset = 1'b0;
    @(posedge clk); #1 en0 = 1'b0;
    chk_bit("post-reset sof tuser", tuser0, 1'b1);
    chk("post-reset sof tdata", 32'(tdata0), 32'd0);
    wait_drain("post-reset", 50);
    chk("post-reset frame_count", fc0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
